adder_serial_nbit: RTL and testbench

- Parametrised multi-cycle adder/subtractor.
- Next generation of the team's fixed-width ripple-carry adders.
- Processes a WIDTH-bit operand pair CHUNK bits per cycle, LSB chunk first, through one shared CHUNK-bit ripple slice.
- Trades latency for area. Sits between operand producers and consumers behind valid/ready handshakes.

---
 rtl/adder_pkg.sv | 19 +
 rtl/adder_chunk.sv | 29 ++
 rtl/full_adder.sv | 11 +
 rtl/adder_serial_nbit.sv | 124 ++++++++++++
 tb/tb_adder_serial_nbit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the serial adder family.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return (chunk > 0) ? (width / chunk) : 1;
  endfunction

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple slice of full_adder cells; combinational.
// Also exports the carry into the MSB so the caller can derive signed overflow.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_cmsb
);
  logic [CHUNK:0] w_c;

  assign w_c[0] = i_ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .i_a  (i_a[i]),
      .i_b  (i_b[i]),
      .i_ci (w_c[i]),
      .o_s  (o_s[i]),
      .o_co (w_c[i+1])
    );
  end

  assign o_co   = w_c[CHUNK];
  assign o_cmsb = w_c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

// File: rtl/adder_serial_nbit.sv
// Serial WIDTH-bit add/sub, CHUNK bits per cycle; out_valid rises NCHUNK cycles after accept.
// Result held in DONE under out_ready back-pressure; ADDER_SERIAL_OVF_EN adds signed-overflow port o_ovf.
module adder_serial_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
`ifdef ADDER_SERIAL_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_cout
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = cnt_width(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("adder_serial_nbit: CHUNK must be >= 1 and divide WIDTH >= 1");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_ci;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic [CHUNK-1:0]   w_s;
  logic               w_co;
`ifdef ADDER_SERIAL_OVF_EN
  logic               r_ovf;
  logic               w_cmsb;
`else
  logic               w_unused_cmsb;
`endif

  // Operands shift right each ADD cycle, so the slice always sees bits [CHUNK-1:0].
  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .i_a    (r_a[CHUNK-1:0]),
    .i_b    (r_b[CHUNK-1:0]),
    .i_ci   (r_ci),
    .o_s    (w_s),
    .o_co   (w_co),
`ifdef ADDER_SERIAL_OVF_EN
    .o_cmsb (w_cmsb)
`else
    .o_cmsb (w_unused_cmsb)
`endif
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_ci        <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid && r_in_ready) begin
            r_a        <= i_a;
            r_b        <= i_sub ? ~i_b : i_b;
            r_ci       <= i_sub | i_cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_sum[int'(r_cnt)*CHUNK +: CHUNK] <= w_s;
          r_a   <= r_a >> CHUNK;
          r_b   <= r_b >> CHUNK;
          r_ci  <= w_co;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(NCHUNK - 1)) begin
            r_cout      <= w_co;
`ifdef ADDER_SERIAL_OVF_EN
            r_ovf       <= w_co ^ w_cmsb;
`endif
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
`ifdef ADDER_SERIAL_OVF_EN
  assign o_ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_adder_serial_nbit.sv
// Directed bench: 16/4 instance checked every cycle against an arithmetic model, plus an 8/8 instance.
module tb_adder_serial_nbit;
  localparam int W = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic [W-1:0]  a = '0, b = '0, sum;
  logic          out_valid, out_ready = 1'b0, cout;
  logic          ovf;
  logic          in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, cout8;
  logic [7:0]    a8 = '0, b8 = '0, sum8;
  int            n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  adder_serial_nbit #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_cin(cin), .i_sub(sub),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_sum(sum),
`ifdef ADDER_SERIAL_OVF_EN
    .o_ovf(ovf),
`endif
    .o_cout(cout)
  );

`ifndef ADDER_SERIAL_OVF_EN
  assign ovf = 1'b0;
`endif

  adder_serial_nbit #(.WIDTH(8), .CHUNK(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid8), .o_in_ready(in_ready8),
    .i_a(a8), .i_b(b8), .i_cin(1'b0), .i_sub(1'b0),
    .o_out_valid(out_valid8), .i_out_ready(out_ready8), .o_sum(sum8),
`ifdef ADDER_SERIAL_OVF_EN
    .o_ovf(),
`endif
    .o_cout(cout8)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: plain integer arithmetic on the operands.
  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           t0;
  } exp_t;

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t e;
    int   ua, ub, sa, sb, ur, sr;
    ua = int'(ma); ub = int'(mb);
    sa = int'($signed(ma)); sb = int'($signed(mb));
    if (ms) begin
      ur = ua - ub;
      sr = sa - sb;
      e.c = (ua >= ub);
    end else begin
      ur = ua + ub + int'(mc);
      sr = sa + sb + int'(mc);
      e.c = (ur >= 65536);
    end
    e.s  = ur[W-1:0];
    e.v  = (sr > 32767) || (sr < -32768);
    e.t0 = 0;
    return e;
  endfunction

  exp_t q[$];
  int   ncyc = 0;
  bit   seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL mon_spurious_valid: got out_valid=1, expected 0 with nothing pending");
        end else begin
          if (!seen) begin
            chk("mon_latency", ncyc - q[0].t0 - 1, LAT);
            seen = 1'b1;
          end
          chk("mon_sum", sum, q[0].s);
          chk("mon_cout", cout, q[0].c);
`ifdef ADDER_SERIAL_OVF_EN
          chk("mon_ovf", ovf, q[0].v);
`endif
          chk("mon_in_ready_done", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        e = model(a, b, cin, sub);
        e.t0 = ncyc;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
    int n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input int hold, output logic [W-1:0] rs, output logic rc, output logic rv);
    int n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) begin
      n_chk++; n_err++;
      $display("FAIL recv_timeout: got out_valid=0, expected 1 within 50 cycles");
    end
    rs = sum; rc = cout; rv = ovf;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_xfer", in_ready, 1);
    chk("out_valid_after_xfer", out_valid, 0);
  endtask

  task automatic op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                    input logic tc, input logic ts, input logic [W-1:0] xs, input logic xc);
    logic [W-1:0] rs;
    logic rc, rv;
    send(ta, tb, tc, ts);
    recv(0, rs, rc, rv);
    chk({name, "_sum"}, rs, xs);
    chk({name, "_cout"}, rc, xc);
  endtask

  initial begin
    logic [W-1:0] rs;
    logic rc, rv;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    op("add_basic", 16'h1234, 16'h0FF0, 1'b0, 1'b0, 16'h2224, 1'b0);
    op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    op("add_cin",   16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0);
    op("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    op("sub_minneg", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1);

`ifdef ADDER_SERIAL_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    recv(0, rs, rc, rv);
    chk("ovf_sum", rs, 16'h8000);
    chk("ovf_flag", rv, 1);
`endif

    // Back-pressure: result held for 3 cycles while a second request is offered.
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    for (int n = 0; n < 50 && !out_valid; n++) begin @(posedge clk); #1; end
    a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_sum", sum, 16'h1000);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    chk("bp_sum_held", sum, 16'h1000);
    @(posedge clk); #1;
    chk("bp_no_phantom", out_valid, 0);

    // Reset after two ADD cycles abandons the operation.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    op("after_rst", 16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0);

    // Single-chunk configuration: one ADD cycle.
    a8 = 8'hC8; b8 = 8'h64; in_valid8 = 1'b1;
    chk("w8_in_ready", in_ready8, 1);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    chk("w8_not_yet", out_valid8, 0);
    @(posedge clk); #1;
    chk("w8_out_valid", out_valid8, 1);
    chk("w8_sum", sum8, 8'h2C);
    chk("w8_cout", cout8, 1);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("w8_in_ready_after", in_ready8, 1);

    repeat (3) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL mon_leftover: got %0d pending results, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
